// File: rtl/alu_operand_sequencer_if.sv
`timescale 1ns/1ps
// Instruction handshake, ALU operand/result and retire-pulse bundle for alu_operand_sequencer.
interface alu_operand_sequencer_if;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned INSTR_W = 16;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [OP_W-1:0]    alu_cntrl;
    logic [DATA_W-1:0]  alu_result;
    logic               done;
    logic               err;

    // master: instruction source plus the ALU returning its result
    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_a, alu_b, alu_cntrl, done, err
    );

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_a, alu_b, alu_cntrl, done, err
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
`timescale 1ns/1ps
// Issue/writeback stage in front of the 8-bit ALU with an 8x8 register file (r0 reads zero).
// Optional retired/illegal counters are built when OPSEQ_PERF_EN is defined.
module alu_operand_sequencer #(
    parameter int unsigned NREGS     = 8,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_operand_sequencer_if.slave bus,
    input  logic [2:0]             dbg_addr,
    output logic [7:0]             dbg_data
`ifdef OPSEQ_PERF_EN
    ,
    output logic [15:0]            retired_cnt,
    output logic [7:0]             illegal_cnt
`endif
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned OP_W   = 4;
    localparam logic [OP_W-1:0] OP_LOADI = 4'hF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_cntrl_q, alu_cntrl_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   regs [NREGS];

    logic [OP_W-1:0]     f_op;
    logic [AW-1:0]       f_rd, f_rs1, f_rs2;
    logic [DATA_W-1:0]   f_imm;
    logic [DATA_W-1:0]   rs1_val, rs2_val;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h9, 4'hA: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    assign f_op  = bus.instr[15:12];
    assign f_rd  = bus.instr[11:9];
    assign f_rs1 = bus.instr[8:6];
    assign f_rs2 = bus.instr[5:3];
    assign f_imm = bus.instr[7:0];

    // r0 is hardwired to zero on every read port
    assign rs1_val  = (f_rs1 == '0)    ? '0 : regs[f_rs1];
    assign rs2_val  = (f_rs2 == '0)    ? '0 : regs[f_rs2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cntrl_q <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cntrl_q <= alu_cntrl_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state, operand capture and writeback decode
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cntrl_d = alu_cntrl_q;
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = bus.alu_result;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    op_d    = f_op;
                    rd_d    = f_rd;
                    imm_d   = f_imm;
                    state_d = EXEC;
                    // LOADI and illegal ops leave the ALU inputs untouched
                    if (is_alu_op(f_op)) begin
                        alu_a_d     = rs1_val;
                        alu_b_d     = rs2_val;
                        alu_cntrl_d = f_op;
                    end
                end
            end
            EXEC: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (is_alu_op(op_q)) begin
                    wr_en   = (rd_q != '0);
                    wr_data = bus.alu_result;
                end else if (op_q == OP_LOADI) begin
                    wr_en   = (rd_q != '0);
                    wr_data = imm_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs[rd_q] <= wr_data;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_cntrl   = alu_cntrl_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

`ifdef OPSEQ_PERF_EN
    localparam int unsigned RET_W = 16;
    localparam int unsigned ILL_W = 8;

    logic [RET_W-1:0] retired_q;
    logic [ILL_W-1:0] illegal_q;

    // Saturating counters, updated on the same edge that raises done/err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            illegal_q <= '0;
        end else begin
            if (done_d && (retired_q != '1)) begin
                retired_q <= retired_q + RET_W'(1);
            end
            if (err_d && (illegal_q != '1)) begin
                illegal_q <= illegal_q + ILL_W'(1);
            end
        end
    end

    assign retired_cnt = retired_q;
    assign illegal_cnt = illegal_q;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for alu_operand_sequencer: directed plan plus random instruction stream
// checked against an architectural register-file model and a behavioural ALU.
module tb_alu_operand_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_sequencer_if bus ();
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
`ifdef OPSEQ_PERF_EN
    logic [15:0] retired_cnt;
    logic [7:0]  illegal_cnt;
`endif

    alu_operand_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`ifdef OPSEQ_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h9:    return a << b[2:0];
            4'hA:    return a >> b[2:0];
            4'h8:    return (a < b) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h9, 4'hA};
    endfunction

    function automatic logic [15:0] mk_op(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] mk_loadi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'hF, rd, 1'b0, imm};
    endfunction

    // Behavioural ALU driven by the sequencer's registered operands
    always_comb bus.alu_result = ref_alu(bus.alu_cntrl, bus.alu_a, bus.alu_b);

    int cmp_cnt = 0;
    int bad_cnt = 0;

    logic [7:0] m_reg [8];
    logic [7:0] m_a, m_b;
    logic [3:0] m_c;
    int         m_retired, m_illegal;
    time        prev_acc;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_a = 8'h00; m_b = 8'h00; m_c = 4'h0;
        m_retired = 0; m_illegal = 0;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    // Offer one instruction, follow it through EXEC and retire, checking against the model
    task automatic issue(input logic [15:0] ins, input bit keep_valid, input bit chk_spacing);
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm;
        bit         legal, loadi;
        int         waited;
        time        acc_t;
        op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3]; imm = ins[7:0];
        legal = is_legal(op);
        loadi = (op == 4'hF);
        waited = 0;

        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        while (bus.instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("ready_wait", {15'h0, bus.instr_ready}, 16'h0001);
        @(posedge clk);
        acc_t = $time;
        if (chk_spacing) check("accept_spacing", 16'((acc_t - prev_acc) / 10), 16'd2);
        prev_acc = acc_t;
        #1;
        if (legal) begin
            m_a = m_reg[rs1]; m_b = m_reg[rs2]; m_c = op;
        end
        check("exec_ready", {15'h0, bus.instr_ready}, 16'h0000);
        check("exec_done", {15'h0, bus.done}, 16'h0000);
        check("exec_alu_a", {8'h00, bus.alu_a}, {8'h00, m_a});
        check("exec_alu_b", {8'h00, bus.alu_b}, {8'h00, m_b});
        check("exec_alu_cntrl", {12'h000, bus.alu_cntrl}, {12'h000, m_c});
        if (!keep_valid) bus.instr_valid = 1'b0;

        @(posedge clk);
        #1;
        if (legal && rd != 3'd0) m_reg[rd] = ref_alu(op, m_a, m_b);
        if (loadi && rd != 3'd0) m_reg[rd] = imm;
        if (m_retired < 65535) m_retired++;
        if (!legal && !loadi && m_illegal < 255) m_illegal++;
        check("retire_done", {15'h0, bus.done}, 16'h0001);
        check("retire_err", {15'h0, bus.err}, {15'h0, !legal && !loadi});
        check("retire_ready", {15'h0, bus.instr_ready}, 16'h0001);
        read_chk("retire_rd", rd, m_reg[rd]);
`ifdef OPSEQ_PERF_EN
        check("retired_cnt", retired_cnt, 16'(m_retired));
        check("illegal_cnt", {8'h00, illegal_cnt}, 16'(m_illegal));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op_tab [10];
        logic [3:0] ill_tab [8];
        logic [3:0] op;
        op_tab  = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h9, 4'hA, 4'hF, 4'hF, 4'h3};
        ill_tab = '{4'h3, 4'h4, 4'h5, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE};
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0000;
        dbg_addr = 3'd0;
        prev_acc = 0;
        model_reset();

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_alu_a", {8'h00, bus.alu_a}, 16'h0000);
        check("rst_alu_b", {8'h00, bus.alu_b}, 16'h0000);
        check("rst_alu_cntrl", {12'h000, bus.alu_cntrl}, 16'h0000);
        check("rst_done", {15'h0, bus.done}, 16'h0000);
        check("rst_err", {15'h0, bus.err}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {15'h0, bus.instr_ready}, 16'h0001);
        check("post_rst_done", {15'h0, bus.done}, 16'h0000);
        for (int i = 0; i < 8; i++) read_chk("rst_reg", 3'(i), 8'h00);

        // LOADI / ADD
        issue(mk_loadi(3'd1, 8'h0F), 1'b0, 1'b0);
        issue(mk_loadi(3'd2, 8'h33), 1'b0, 1'b0);
        issue(mk_op(4'h2, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0);
        read_chk("add_r3", 3'd3, 8'h42);

        // SUB wrap and SLT both ways
        issue(mk_loadi(3'd1, 8'hF0), 1'b0, 1'b0);
        issue(mk_loadi(3'd2, 8'h20), 1'b0, 1'b0);
        issue(mk_op(4'h6, 3'd4, 3'd2, 3'd1), 1'b0, 1'b0);
        read_chk("sub_r4", 3'd4, 8'h30);
        issue(mk_op(4'h8, 3'd5, 3'd1, 3'd2), 1'b0, 1'b0);
        read_chk("slt_r5", 3'd5, 8'h00);
        issue(mk_op(4'h8, 3'd6, 3'd2, 3'd1), 1'b0, 1'b0);
        read_chk("slt_r6", 3'd6, 8'h01);

        // Back-to-back dependent ops with instr_valid held high
        issue(mk_loadi(3'd1, 8'h05), 1'b1, 1'b0);
        issue(mk_op(4'h2, 3'd3, 3'd1, 3'd1), 1'b1, 1'b1);
        read_chk("b2b_r3_first", 3'd3, 8'h0A);
        issue(mk_op(4'h2, 3'd3, 3'd3, 3'd3), 1'b0, 1'b1);
        read_chk("b2b_r3_second", 3'd3, 8'h14);

        // Illegal op leaves r7 and ALU inputs alone; r0 ignores writes
        issue(mk_loadi(3'd7, 8'h77), 1'b0, 1'b0);
        issue(mk_op(4'h3, 3'd7, 3'd1, 3'd2), 1'b0, 1'b0);
        read_chk("illegal_r7", 3'd7, 8'h77);
        issue(mk_loadi(3'd0, 8'hAA), 1'b0, 1'b0);
        read_chk("loadi_r0", 3'd0, 8'h00);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            op = op_tab[$urandom_range(0, 9)];
            if (op == 4'h3) op = ill_tab[$urandom_range(0, 7)];
            if (op == 4'hF)
                issue(mk_loadi(3'($urandom_range(0, 7)), 8'($urandom)), 1'b0, 1'b0);
            else
                issue(mk_op(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                            3'($urandom_range(0, 7))), 1'b0, 1'b0);
        end

        // Reset during EXEC aborts the instruction
        issue(mk_loadi(3'd1, 8'h05), 1'b0, 1'b0);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = mk_op(4'h2, 3'd3, 3'd1, 3'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        check("abort_exec_ready", {15'h0, bus.instr_ready}, 16'h0000);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_done", {15'h0, bus.done}, 16'h0000);
        check("abort_alu_a", {8'h00, bus.alu_a}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_no_done", {15'h0, bus.done}, 16'h0000);
        check("abort_no_err", {15'h0, bus.err}, 16'h0000);
        read_chk("abort_r3", 3'd3, 8'h00);
        read_chk("abort_r1", 3'd1, 8'h00);
`ifdef OPSEQ_PERF_EN
        check("abort_retired_cnt", retired_cnt, 16'h0000);
        check("abort_illegal_cnt", {8'h00, illegal_cnt}, 16'h0000);
`endif
        issue(mk_loadi(3'd2, 8'h3C), 1'b0, 1'b0);
        issue(mk_op(4'h1, 3'd4, 3'd2, 3'd0), 1'b0, 1'b0);
        read_chk("after_abort_r4", 3'd4, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Issue/writeback stage that sits directly upstream of the 8-bit ALU. Holds an 8-entry x 8-bit register file.
- Accepts one 16-bit instruction per handshake and decodes it. Drives registered A/B/cntrl into the ALU, samples the ALU result and writes it back to the destination register.
- Fixed 2-cycle issue-to-writeback latency; one instruction in flight at a time.

Parameters:
- NREGS, 8, register-file depth; must be 8 because of the 3-bit register fields.
- RESET_VAL, 8'h00, reset value of every register-file entry.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LOADI only)
- instr_ready  out  1  sequencer can accept an instruction
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_cntrl  out  4  ALU control (registered)
- alu_result  in  8  combinational result returned by the ALU
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  one-cycle pulse: illegal opcode retired
- dbg_addr  in  3  debug read address
- dbg_data  out  8  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all regs=RESET_VAL.
  - alu_a=alu_b=0, alu_cntrl=4'b0000, done=err=0. instr_ready goes high on the first cycle after reset release.
- Legal ALU ops: op in {0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1001 SHL, 1010 SHR, 1000 SLT}.
- Op 1111 is LOADI (rd <= imm). Every other op is illegal.
- r0 is hardwired to zero: reads return 0 and writes to rd=0 are discarded.
- FSM:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready the edge captures op/rd/imm.
    - Legal op: alu_a<=reg[rs1], alu_b<=reg[rs2], alu_cntrl<=op.
    - LOADI or illegal op: alu_a, alu_b and alu_cntrl are held at their previous values (never x).
    - Next state is EXEC.
  - EXEC: instr_ready=0. The ALU output is valid combinationally in this cycle. At the end-of-EXEC edge:
    - ALU op: reg[rd]<=alu_result.
    - LOADI: reg[rd]<=imm.
    - Illegal op: no write.
    - Then done<=1 for all ops, err<=1 for illegal ops only, next state IDLE.
- Throughput: one instruction per 2 cycles. done/err are high during the IDLE cycle that follows EXEC, which is also the cycle in which the next instruction can be accepted.
- Operand hazards: none. Writeback completes before the next capture, so back-to-back dependent instructions see the updated value.
- Arithmetic: all 8-bit, wrap-around, no carry or flags kept. Shift and compare semantics belong to the ALU.
- instr_valid while instr_ready=0 is ignored; the sender must hold instr until accepted.
- dbg_data is a combinational read. A write on the current edge becomes visible in the following cycle.
- Reset asserted mid-EXEC aborts the instruction: no writeback, no done, all regs return to RESET_VAL.

Optional Feature:
- Macro: OPSEQ_PERF_EN.
- Defined:
  - Adds outputs retired_cnt[15:0] and illegal_cnt[7:0].
  - retired_cnt increments on every done; illegal_cnt increments on every err.
  - Both counters saturate at all-ones, with no wrap. Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then read dbg_addr 0..7 -> all read 8'h00; instr_ready=1, done=0, err=0.
- LOADI r1=0x0F; LOADI r2=0x33; ADD r3=r1+r2 -> ADD shows alu_a=0x0F, alu_b=0x33, alu_cntrl=0010 in EXEC; done pulses once per instruction; dbg r3=0x42.
- LOADI r1=0xF0, r2=0x20; SUB r4=r2-r1 -> r4=0x30 (wrap); then SLT r5=r1<r2 -> r5=0x00, and SLT r6=r2<r1 -> r6=0x01.
- Back-to-back dependent ops: ADD r3=r1+r1, then ADD r3=r3+r3 with r1=0x05 -> r3=0x0A then 0x14; instr_valid held high throughout; each instruction accepted exactly 2 cycles after the previous one.
- Illegal op 0011 with rd=7 -> err and done pulse together, r7 unchanged, alu_cntrl never x; LOADI r0=0xAA -> r0 still reads 0.
- Assert rst_n low during EXEC of ADD r3 -> r3=0x00 after reset, no done pulse; with OPSEQ_PERF_EN, retired_cnt=0 after reset.
